// File: rtl/rx_frame_pkg.sv
// Shared constants, FSM state type and bit helper for the RMII receive frame checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rx_frame_pkg;

  // Reflected CRC-32 (IEEE 802.3) constants.
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left behind once a correct FCS has been run through the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Bit positions inside out_status.
  localparam int ST_CRC_ERR = 0;
  localparam int ST_RUNT    = 1;
  localparam int ST_GIANT   = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_STREAM  = 2'd2,
    S_DISCARD = 2'd3
  } rx_state_e;

  // The FIFO stores each octet MSB-first; this restores wire order (bit0 first).
  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte combinational update of the reflected CRC-32 register.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: crc_in - current CRC register, d - data octet (bit0 = first on wire),
//        crc_out - register after absorbing d.
module crc32_d8
  import rx_frame_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_frame_checker.sv
// Pops {EOD,byte} words from the RX FIFO, checks CRC-32 and length, strips the FCS and streams payload.
// Latency: a payload byte leaves 4 FIFO bytes after it was popped (holdback of the trailing FCS).
// Backpressure: out_valid/out_ready; one byte of output buffering, FIFO reads stall while it is held.
// Ports:
//   clk, arst_n                  user clock, asynchronous active-low reset
//   fifo_empty/fifo_dout/fifo_EOD_out/fifo_rden   FIFO read side, data valid the cycle after fifo_rden
//   out_data/out_valid/out_ready/out_sof/out_eof  payload byte stream to the switch core
//   out_status/out_len           per-frame {giant,runt,crc_err} and payload length, valid with out_eof
//   good_count/crc_err_count/len_err_count        wrapping 16-bit frame counters
module rx_frame_checker
  import rx_frame_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_EOD_out,
  output logic        fifo_rden,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [2:0]  out_status,
  output logic [10:0] out_len,
  output logic [15:0] good_count,
  output logic [15:0] crc_err_count,
  output logic [15:0] len_err_count
);

  localparam logic [10:0] MIN_LEN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_L   = 11'(MAX_LEN);
  localparam logic [10:0] GIANT_LEN_L = 11'(MAX_LEN + 1);

  rx_state_e       state_q, state_d;
  logic [3:0][7:0] hold_q, hold_d;      // [0] newest, [3] oldest
  logic [31:0]     crc_q, crc_d;
  logic [10:0]     len_q, len_d;        // bytes of this frame seen so far, FCS included
  logic            sof_pend_q, sof_pend_d;
  logic            rd_inflight_q, rd_inflight_d;
  logic            run_q, run_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;
  logic [2:0]      out_status_q, out_status_d;
  logic [10:0]     out_len_q, out_len_d;
  logic [15:0]     good_cnt_q, good_cnt_d;
  logic [15:0]     crc_cnt_q, crc_cnt_d;
  logic [15:0]     lerr_cnt_q, lerr_cnt_d;

  logic [7:0]  rx_byte;
  logic [31:0] crc_seed;
  logic [31:0] crc_nxt;
  logic [10:0] len_inc;
  logic        handoff;
  logic        eof_acc;
  logic        drop_frame;

  assign rx_byte  = bitrev8(fifo_dout);
  // The first byte of a frame always meets a freshly initialised CRC.
  assign crc_seed = (state_q == S_IDLE) ? CRC_INIT : crc_q;

  crc32_d8 u_crc (
    .crc_in  (crc_seed),
    .d       (rx_byte),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    crc_d        = crc_q;
    len_d        = len_q;
    sof_pend_d   = sof_pend_q;
    run_d        = 1'b1;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;
    out_status_d = out_status_q;
    out_len_d    = out_len_q;
    drop_frame   = 1'b0;

    handoff = out_valid_q & out_ready;
    // A read is only issued when its byte is guaranteed a free output slot on arrival:
    // the output register is only ever loaded by an arriving byte, and only one read is outstanding.
    fifo_rden     = run_q & ~fifo_empty & ~rd_inflight_q & (~out_valid_q | handoff);
    rd_inflight_d = fifo_rden;
    len_inc       = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;

    if (handoff) begin
      out_valid_d = 1'b0;
    end

    if (rd_inflight_q) begin
      case (state_q)
        S_IDLE: begin
          if (fifo_EOD_out) begin
            drop_frame = 1'b1;
          end else begin
            hold_d     = '0;
            hold_d[0]  = rx_byte;
            crc_d      = crc_nxt;
            len_d      = 11'd1;
            sof_pend_d = 1'b1;
            state_d    = S_FILL;
          end
        end
        S_FILL: begin
          if (fifo_EOD_out) begin
            // Frame shorter than FCS + 1 byte: nothing to deliver.
            drop_frame = 1'b1;
            hold_d     = '0;
            len_d      = '0;
            state_d    = S_IDLE;
          end else begin
            hold_d = {hold_q[2:0], rx_byte};
            crc_d  = crc_nxt;
            len_d  = len_inc;
            if (len_q == 11'd3) begin
              state_d = S_STREAM;
            end
          end
        end
        S_STREAM: begin
          out_valid_d  = 1'b1;
          out_data_d   = hold_q[3];
          out_sof_d    = sof_pend_q;
          out_eof_d    = 1'b0;
          out_status_d = '0;
          out_len_d    = '0;
          sof_pend_d   = 1'b0;
          hold_d       = {hold_q[2:0], rx_byte};
          crc_d        = crc_nxt;
          len_d        = len_inc;
          if (fifo_EOD_out) begin
            // The EOD byte and the three newest held bytes are the FCS.
            out_eof_d                = 1'b1;
            out_status_d[ST_CRC_ERR] = (crc_nxt != CRC_RESIDUE);
            out_status_d[ST_RUNT]    = (len_inc < MIN_LEN_L);
            out_status_d[ST_GIANT]   = (len_inc > MAX_LEN_L);
            out_len_d                = len_inc - 11'd4;
            hold_d                   = '0;
            len_d                    = '0;
            state_d                  = S_IDLE;
          end else if (len_inc == GIANT_LEN_L) begin
            // Truncate: close the frame now and throw the rest away up to EOD.
            out_eof_d              = 1'b1;
            out_status_d[ST_GIANT] = 1'b1;
            out_len_d              = len_inc - 11'd4;
            hold_d                 = '0;
            len_d                  = '0;
            state_d                = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (fifo_EOD_out) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    eof_acc    = handoff & out_eof_q;
    good_cnt_d = good_cnt_q + {15'd0, eof_acc & (out_status_q == 3'b000)};
    crc_cnt_d  = crc_cnt_q + {15'd0, eof_acc & out_status_q[ST_CRC_ERR]};
    lerr_cnt_d = lerr_cnt_q
               + {15'd0, eof_acc & (out_status_q[ST_RUNT] | out_status_q[ST_GIANT])}
               + {15'd0, drop_frame};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      crc_q         <= '0;
      len_q         <= '0;
      sof_pend_q    <= 1'b0;
      rd_inflight_q <= 1'b0;
      run_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      out_status_q  <= '0;
      out_len_q     <= '0;
      good_cnt_q    <= '0;
      crc_cnt_q     <= '0;
      lerr_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      crc_q         <= crc_d;
      len_q         <= len_d;
      sof_pend_q    <= sof_pend_d;
      rd_inflight_q <= rd_inflight_d;
      run_q         <= run_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sof_q     <= out_sof_d;
      out_eof_q     <= out_eof_d;
      out_status_q  <= out_status_d;
      out_len_q     <= out_len_d;
      good_cnt_q    <= good_cnt_d;
      crc_cnt_q     <= crc_cnt_d;
      lerr_cnt_q    <= lerr_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = out_eof_q;
  assign out_status    = out_status_q;
  assign out_len       = out_len_q;
  assign good_count    = good_cnt_q;
  assign crc_err_count = crc_cnt_q;
  assign len_err_count = lerr_cnt_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: FIFO model feeds frames, expected payload queued per byte.
// Latency: n/a (testbench).
// Backpressure: out_ready driven by the bench, stalled in the backpressure scenario.
module tb_rx_frame_checker;

  typedef logic [23:0] obs_t;   // {data, sof, eof, status, len}

  logic        clk          = 1'b0;
  logic        arst_n       = 1'b0;
  logic        fifo_empty   = 1'b1;
  logic [7:0]  fifo_dout    = 8'd0;
  logic        fifo_EOD_out = 1'b0;
  logic        out_ready    = 1'b0;
  logic        fifo_rden;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [2:0]  out_status;
  logic [10:0] out_len;
  logic [15:0] good_count;
  logic [15:0] crc_err_count;
  logic [15:0] len_err_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0] fifo_q[$];   // {eod, stored byte}
  obs_t       sb[$];
  logic [8:0] fw;
  logic       rden_prev = 1'b0;
  int         rden_b2b  = 0;

  always #5 clk = ~clk;

  rx_frame_checker #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout),
    .fifo_EOD_out  (fifo_EOD_out),
    .fifo_rden     (fifo_rden),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_status    (out_status),
    .out_len       (out_len),
    .good_count    (good_count),
    .crc_err_count (crc_err_count),
    .len_err_count (len_err_count)
  );

  // Show-ahead-free FIFO model: data appears the cycle after the pop; shares the system reset.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fifo_q.delete();
      fifo_empty   <= 1'b1;
      fifo_dout    <= 8'd0;
      fifo_EOD_out <= 1'b0;
      rden_prev    <= 1'b0;
    end else begin
      if (fifo_rden && fifo_q.size() != 0) begin
        fw = fifo_q.pop_front();
        fifo_EOD_out <= fw[8];
        fifo_dout    <= fw[7:0];
      end
      if (fifo_rden && rden_prev) rden_b2b <= rden_b2b + 1;
      rden_prev  <= fifo_rden;
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  function automatic logic [7:0] brev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  function automatic logic [7:0] pbyte(input int seed, input int i);
    return 8'(seed * 53 + i * 29 + (i >> 4));
  endfunction

  // Pushes n payload bytes (optionally plus a correct FCS) into the FIFO and the first exp_n
  // payload bytes into the scoreboard; flip >= 0 corrupts bit 3 of that byte after the CRC.
  task automatic load_frame(input int n, input int seed, input int flip, input bit fcs,
                            input bit eod, input int exp_n, input bit exp_eof,
                            input logic [2:0] exp_st, input logic [10:0] exp_len);
    logic [31:0] c;
    logic [31:0] f;
    logic [7:0]  p;
    logic        last;
    int          total;
    c = 32'hFFFFFFFF;
    total = fcs ? n + 4 : n;
    for (int i = 0; i < n; i++) begin
      p = pbyte(seed, i);
      c = crc8(c, p);
      if (i == flip) p = p ^ 8'h08;
      fifo_q.push_back({eod && (i == total - 1), brev(p)});
      if (i < exp_n) begin
        last = exp_eof && (i == exp_n - 1);
        sb.push_back({p, i == 0, last, last ? exp_st : 3'b000, last ? exp_len : 11'd0});
      end
    end
    if (fcs) begin
      f = ~c;
      for (int k = 0; k < 4; k++) fifo_q.push_back({eod && (k == 3), brev(f[8*k +: 8])});
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({fifo_rden, out_valid, out_sof, out_eof, out_status, out_len, out_data} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0",
               {fifo_rden, out_valid, out_sof, out_eof, out_status, out_len, out_data});
    end
    vectors++;
    if ({good_count, crc_err_count, len_err_count} !== 48'd0) begin
      miscompares++;
      $display("FAIL reset_counters got=%h exp=0", {good_count, crc_err_count, len_err_count});
    end
    arst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    obs_t got, exp;
    int   idle;
    @(negedge clk);
    load_frame(60, 1, -1, 1'b1, 1'b1, 60, 1'b1, 3'b000, 11'd60);
    idle = 0;
    for (int c = 0; c < 5000 && idle < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_data, out_sof, out_eof, out_eof ? out_status : 3'b0, out_eof ? out_len : 11'd0};
        if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL good_byte got=%h exp=%h", got, exp); end
      end
      idle = (sb.size() == 0 && fifo_q.size() == 0) ? idle + 1 : 0;
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL good_drain left=%0d exp=0", sb.size()); end
    vectors++;
    if (good_count !== 16'd1) begin miscompares++; $display("FAIL good_count got=%0d exp=1", good_count); end
  endtask

  task automatic test_crc_error();
    obs_t got, exp;
    int   idle;
    @(negedge clk);
    load_frame(60, 1, 9, 1'b1, 1'b1, 60, 1'b1, 3'b001, 11'd60);
    idle = 0;
    for (int c = 0; c < 5000 && idle < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_data, out_sof, out_eof, out_eof ? out_status : 3'b0, out_eof ? out_len : 11'd0};
        if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL crc_byte got=%h exp=%h", got, exp); end
      end
      idle = (sb.size() == 0 && fifo_q.size() == 0) ? idle + 1 : 0;
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL crc_drain left=%0d exp=0", sb.size()); end
    vectors++;
    if ({good_count, crc_err_count, len_err_count} !== {16'd1, 16'd1, 16'd0}) begin
      miscompares++;
      $display("FAIL crc_counters got=%0d/%0d/%0d exp=1/1/0", good_count, crc_err_count, len_err_count);
    end
  endtask

  // Back-to-back: 3-byte frame (dropped), 1-byte payload runt, then a good frame.
  task automatic test_runt_drop();
    obs_t got, exp;
    int   idle;
    @(negedge clk);
    load_frame(3, 2, -1, 1'b0, 1'b1, 0, 1'b0, 3'b000, 11'd0);
    load_frame(1, 3, -1, 1'b1, 1'b1, 1, 1'b1, 3'b010, 11'd1);
    load_frame(60, 4, -1, 1'b1, 1'b1, 60, 1'b1, 3'b000, 11'd60);
    idle = 0;
    for (int c = 0; c < 5000 && idle < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_data, out_sof, out_eof, out_eof ? out_status : 3'b0, out_eof ? out_len : 11'd0};
        if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL runt_drop_byte got=%h exp=%h", got, exp); end
      end
      idle = (sb.size() == 0 && fifo_q.size() == 0) ? idle + 1 : 0;
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL runt_drop_drain left=%0d exp=0", sb.size()); end
    vectors++;
    if ({good_count, crc_err_count, len_err_count} !== {16'd2, 16'd1, 16'd2}) begin
      miscompares++;
      $display("FAIL runt_drop_counters got=%0d/%0d/%0d exp=2/1/2", good_count, crc_err_count, len_err_count);
    end
  endtask

  task automatic test_backpressure();
    obs_t got, exp, held;
    int   idle, acc, stall_left, stall_hits, unstable, rd_in_stall;
    bit   held_set;
    @(negedge clk);
    load_frame(60, 5, -1, 1'b1, 1'b1, 60, 1'b1, 3'b000, 11'd60);
    idle = 0; acc = 0; stall_left = 20; stall_hits = 0; unstable = 0; rd_in_stall = 0;
    held_set = 1'b0;
    held = '0;
    for (int c = 0; c < 5000 && idle < 8; c++) begin
      @(negedge clk);
      out_ready = !(acc == 30 && stall_left > 0);
      #1;
      if (!out_ready) begin
        stall_left--;
        if (out_valid) begin
          got = {out_data, out_sof, out_eof, out_status, out_len};
          if (!held_set) begin held = got; held_set = 1'b1; end
          else if (got !== held) unstable++;
          stall_hits++;
          if (fifo_rden) rd_in_stall++;
        end
      end
      if (out_valid && out_ready) begin
        got = {out_data, out_sof, out_eof, out_eof ? out_status : 3'b0, out_eof ? out_len : 11'd0};
        if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
        vectors++;
        acc++;
        if (got !== exp) begin miscompares++; $display("FAIL bp_byte got=%h exp=%h", got, exp); end
      end
      idle = (sb.size() == 0 && fifo_q.size() == 0) ? idle + 1 : 0;
    end
    out_ready = 1'b1;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL bp_drain left=%0d exp=0", sb.size()); end
    vectors++;
    if (unstable != 0) begin miscompares++; $display("FAIL bp_stable changes=%0d exp=0", unstable); end
    vectors++;
    if (rd_in_stall != 0) begin miscompares++; $display("FAIL bp_read_while_full got=%0d exp=0", rd_in_stall); end
    vectors++;
    if (stall_hits < 15) begin miscompares++; $display("FAIL bp_stall_seen got=%0d exp>=15", stall_hits); end
    vectors++;
    if (good_count !== 16'd3) begin miscompares++; $display("FAIL bp_good_count got=%0d exp=3", good_count); end
  endtask

  task automatic test_giant();
    obs_t got, exp;
    int   idle;
    @(negedge clk);
    load_frame(1601, 6, -1, 1'b0, 1'b1, 1519, 1'b1, 3'b100, 11'd1519);
    idle = 0;
    for (int c = 0; c < 6000 && idle < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_data, out_sof, out_eof, out_eof ? out_status : 3'b0, out_eof ? out_len : 11'd0};
        if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL giant_byte got=%h exp=%h", got, exp); end
      end
      idle = (sb.size() == 0 && fifo_q.size() == 0) ? idle + 1 : 0;
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL giant_drain left=%0d exp=0", sb.size()); end
    vectors++;
    if ({good_count, crc_err_count, len_err_count} !== {16'd3, 16'd1, 16'd3}) begin
      miscompares++;
      $display("FAIL giant_counters got=%0d/%0d/%0d exp=3/1/3", good_count, crc_err_count, len_err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t got, exp;
    int   idle;
    @(negedge clk);
    load_frame(30, 7, -1, 1'b0, 1'b0, 26, 1'b0, 3'b000, 11'd0);
    idle = 0;
    for (int c = 0; c < 5000 && idle < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_data, out_sof, out_eof, out_eof ? out_status : 3'b0, out_eof ? out_len : 11'd0};
        if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL partial_byte got=%h exp=%h", got, exp); end
      end
      idle = (sb.size() == 0 && fifo_q.size() == 0) ? idle + 1 : 0;
    end
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    vectors++;
    if ({fifo_rden, out_valid, out_sof, out_eof, out_status, out_len, out_data} !== 26'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {fifo_rden, out_valid, out_sof, out_eof, out_status, out_len, out_data});
    end
    vectors++;
    if ({good_count, crc_err_count, len_err_count} !== 48'd0) begin
      miscompares++;
      $display("FAIL midreset_counters got=%h exp=0", {good_count, crc_err_count, len_err_count});
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    load_frame(60, 8, -1, 1'b1, 1'b1, 60, 1'b1, 3'b000, 11'd60);
    idle = 0;
    for (int c = 0; c < 5000 && idle < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {out_data, out_sof, out_eof, out_eof ? out_status : 3'b0, out_eof ? out_len : 11'd0};
        if (sb.size() != 0) exp = sb.pop_front(); else exp = 'x;
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL post_reset_byte got=%h exp=%h", got, exp); end
      end
      idle = (sb.size() == 0 && fifo_q.size() == 0) ? idle + 1 : 0;
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL post_reset_drain left=%0d exp=0", sb.size()); end
    vectors++;
    if ({good_count, crc_err_count, len_err_count} !== {16'd1, 16'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL post_reset_counters got=%0d/%0d/%0d exp=1/0/0", good_count, crc_err_count, len_err_count);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_runt_drop();
    test_backpressure();
    test_giant();
    test_reset_mid_frame();
    vectors++;
    if (rden_b2b != 0) begin miscompares++; $display("FAIL reads_in_flight b2b=%0d exp=0", rden_b2b); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
